// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution window feeder.
// Tap order is row-major: a0 is top-left (oldest row, oldest column).
// a8 is bottom-right (the newest pixel).
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam int WIN_TAPS = 9;

    localparam int TAP_A0 = 0;
    localparam int TAP_A1 = 1;
    localparam int TAP_A2 = 2;
    localparam int TAP_A3 = 3;
    localparam int TAP_A4 = 4;
    localparam int TAP_A5 = 5;
    localparam int TAP_A6 = 6;
    localparam int TAP_A7 = 7;
    localparam int TAP_A8 = 8;

endpackage

// File: rtl/line_buffer3.sv
// Two-row line buffer with a 3x3 window shift register.
// Each shift_en pulse pushes one pixel into the structure.
// - row_mid delays by one image row.
// - row_top delays by a further row.
// The window gains a new right-hand column {row_top, row_mid, pixel}.
module line_buffer3
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           shift_en,
    input  logic [DATA_WIDTH-1:0]          pix_data,
    output logic [WIN_TAPS*DATA_WIDTH-1:0] win_flat
);

    logic [DATA_WIDTH-1:0] row_mid [IMG_W];
    logic [DATA_WIDTH-1:0] row_top [IMG_W];
    logic [DATA_WIDTH-1:0] taps    [WIN_TAPS];

    // Row delays and window shift, all advanced together by one accepted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IMG_W; i++) begin
                row_mid[i] <= '0;
                row_top[i] <= '0;
            end
            for (int t = 0; t < WIN_TAPS; t++) begin
                taps[t] <= '0;
            end
        end else if (shift_en) begin
            row_mid[0] <= pix_data;
            row_top[0] <= row_mid[IMG_W-1];
            for (int i = 1; i < IMG_W; i++) begin
                row_mid[i] <= row_mid[i-1];
                row_top[i] <= row_top[i-1];
            end
            // top row: pixel from two rows ago, same column
            taps[TAP_A0] <= taps[TAP_A1];
            taps[TAP_A1] <= taps[TAP_A2];
            taps[TAP_A2] <= row_top[IMG_W-1];
            // middle row: pixel from one row ago, same column
            taps[TAP_A3] <= taps[TAP_A4];
            taps[TAP_A4] <= taps[TAP_A5];
            taps[TAP_A5] <= row_mid[IMG_W-1];
            // bottom row: the incoming pixel
            taps[TAP_A6] <= taps[TAP_A7];
            taps[TAP_A7] <= taps[TAP_A8];
            taps[TAP_A8] <= pix_data;
        end
    end

    // Pack taps with a0 in the least significant bits
    always_comb begin
        win_flat = '0;
        for (int t = 0; t < WIN_TAPS; t++) begin
            win_flat[t*DATA_WIDTH +: DATA_WIDTH] = taps[t];
        end
    end

endmodule

// File: rtl/conv_window_feeder.sv
// Feeds 3x3 windows of a raster pixel stream to a serial conv engine.
// It returns each engine result on a valid/ready stream.
// Optional feature: define CONV_RELU_EN to clamp negative results to 0.
//
// Handshake semantics (pixel and result streams): a transfer happens on a
// rising edge where valid and ready are both high. valid, once raised, holds
// its data until that transfer. ready may be driven freely.
module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           pix_valid,
    output logic                           pix_ready,
    input  logic [DATA_WIDTH-1:0]          pix_data,
    output logic [WIN_TAPS*DATA_WIDTH-1:0] win_flat,
    output logic                           conv_start,
    input  logic                           conv_done,
    input  logic [ACC_WIDTH-1:0]           conv_result,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_WIDTH-1:0]           out_data,
    output logic                           frame_done,
    output logic [2:0]                     dbg_state
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    state_t               state;
    state_t               state_next;
    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     row;
    logic                 pix_fire;
    logic                 win_ok;
    logic                 last_win;
    logic                 out_fire;
    logic [ACC_WIDTH-1:0] result_next;

    assign pix_fire  = pix_valid && (state == FILL);
    assign win_ok    = (row >= ROW_TWO) && (col >= COL_TWO);
    assign out_fire  = (state == OUT) && out_ready;
    assign dbg_state = state;

    line_buffer3 #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMG_W      (IMG_W)
    ) u_line_buffer3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (pix_fire),
        .pix_data (pix_data),
        .win_flat (win_flat)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic: one window is in flight at a time
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FILL;
            FILL:    if (pix_fire && win_ok) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (conv_done) state_next = OUT;
            OUT:     if (out_ready) state_next = FILL;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        pix_ready  = 1'b0;
        conv_start = 1'b0;
        out_valid  = 1'b0;
        case (state)
            FILL:    pix_ready  = 1'b1;
            ISSUE:   conv_start = 1'b1;
            OUT:     out_valid  = 1'b1;
            default: ;
        endcase
    end

    // Raster position of the next pixel; wraps to 0,0 after the last pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (pix_fire) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Remember whether the in-flight window is the last one of the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_win <= 1'b0;
        end else if (pix_fire && win_ok) begin
            last_win <= (row == ROW_LAST) && (col == COL_LAST);
        end
    end

    // Optional rectification of the engine result
    always_comb begin
        result_next = conv_result;
`ifdef CONV_RELU_EN
        if (conv_result[ACC_WIDTH-1]) result_next = '0;
`else
        result_next = conv_result;
`endif
    end

    // Result register: loaded only in WAIT, so it is frozen while out_valid is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if ((state == WAIT) && conv_done) begin
            out_data <= result_next;
        end
    end

    // Frame completion pulse, one cycle after the last result transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_done <= 1'b0;
        else        frame_done <= out_fire && last_win;
    end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder on a 4x4 image.
// It carries a behavioural conv engine: dot product of the window and the weights.
// Expected results are hand-computed constants queued in exp_q.
module tb_conv_window_feeder;

    localparam int DW = 8;
    localparam int AW = 32;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam logic [71:0] WIN_ONES = 72'h01_01_01_01_01_01_01_01_01;
`ifdef CONV_RELU_EN
    localparam logic [31:0] NEG9_EXP = 32'd0;
`else
    localparam logic [31:0] NEG9_EXP = 32'hFFFF_FFF7;
`endif

    logic          clk;
    logic          rst_n;
    logic          pix_valid;
    logic          pix_ready;
    logic [DW-1:0] pix_data;
    logic [71:0]   win_flat;
    logic          conv_start;
    logic          conv_done;
    logic [AW-1:0] conv_result;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;
    logic          frame_done;
    logic [2:0]    dbg_state;

    conv_window_feeder #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .IMG_W      (W),
        .IMG_H      (H)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .win_flat    (win_flat),
        .conv_start  (conv_start),
        .conv_done   (conv_done),
        .conv_result (conv_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .frame_done  (frame_done),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int fd_cnt   = 0;
    int n_acc    = 0;
    int n_starts = 0;
    int wide_start = 0;
    int wt [9];
    int lat = 2;
    bit abort = 0;
    bit sender_done = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] dot(input logic [71:0] w);
        int acc;
        acc = 0;
        for (int i = 0; i < 9; i++) begin
            acc += int'($signed(w[i*8 +: 8])) * wt[i];
        end
        return 32'(acc);
    endfunction

    task automatic set_wt(input int all_v, input int center_v);
        for (int i = 0; i < 9; i++) wt[i] = all_v;
        wt[4] = center_v;
    endtask

    // ---------------- behavioural conv engine ----------------
    initial begin : engine
        bit busy;
        bit prev_start;
        int cnt;
        logic [31:0] pend;
        busy = 0; prev_start = 0; cnt = 0; pend = '0;
        conv_done = 1'b0;
        conv_result = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                busy = 0; cnt = 0; prev_start = 0;
                conv_done = 1'b0;
                conv_result = '0;
            end else begin
                conv_done = 1'b0;
                if (conv_start && prev_start) wide_start++;
                if (conv_start) begin
                    n_starts++;
                    busy = 1;
                    cnt  = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
                    pend = dot(win_flat);
                end else if (busy) begin
                    cnt--;
                    if (cnt <= 0) begin
                        conv_done   = 1'b1;
                        conv_result = pend;
                        busy        = 0;
                    end
                end
                prev_start = conv_start;
            end
        end
    end

    // ---------------- monitor: result stream, frame pulses, pixel accepts ----------------
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) check("result_count", 72'(exp_q.size()), 72'd1);
                else check("result", 72'(out_data), 72'(exp_q.pop_front()));
            end
            if (frame_done) fd_cnt++;
            if (pix_valid && pix_ready) n_acc++;
        end
    end

    // ---------------- driver tasks (entered and left at posedge+1) ----------------
    task automatic send_pixel(input logic [DW-1:0] v, input bit stall);
        int t;
        bit done;
        if (stall) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        pix_valid = 1'b1;
        pix_data  = v;
        t = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            if (abort) begin
                pix_valid = 1'b0;
                return;
            end
            if (pix_ready) done = 1;
            else begin
                t++;
                if (t > 300) begin
                    check("pix_accept_timeout", 72'(t), 72'd0);
                    pix_valid = 1'b0;
                    return;
                end
            end
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic send_frame(input bit ramp, input bit stall);
        for (int i = 0; i < W*H; i++) begin
            if (abort) break;
            send_pixel(ramp ? DW'(i) : DW'(1), stall);
        end
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        check(tag, 72'(exp_q.size()), 72'd0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic push_n(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int fd0;
        int acc0;
        int t;
        rst_n = 1'b0; pix_valid = 1'b0; pix_data = '0; out_ready = 1'b1;
        set_wt(1, 1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_ready",  72'(pix_ready),  72'd0);
        check("rst_conv_start", 72'(conv_start), 72'd0);
        check("rst_out_valid",  72'(out_valid),  72'd0);
        check("rst_frame_done", 72'(frame_done), 72'd0);
        check("rst_out_data",   72'(out_data),   72'd0);
        check("rst_win_flat",   win_flat,        72'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_pix_ready", 72'(pix_ready), 72'd0);
        @(posedge clk); #1;
        check("fill_pix_ready", 72'(pix_ready), 72'd1);

        // all ones, weights all 1 -> four 9s and one frame pulse
        set_wt(1, 1); lat = 2;
        push_n(32'd9, 4);
        fd0 = fd_cnt;
        send_frame(0, 0);
        wait_drain("t1_drain");
        check("t1_frame_done", 72'(fd_cnt - fd0), 72'd1);

        // ramp 0..15, center weight only -> 5, 6, 9, 10
        set_wt(0, 1); lat = 1;
        exp_q.push_back(32'd5); exp_q.push_back(32'd6);
        exp_q.push_back(32'd9); exp_q.push_back(32'd10);
        fd0 = fd_cnt;
        send_frame(1, 0);
        wait_drain("t2_drain");
        check("t2_frame_done", 72'(fd_cnt - fd0), 72'd1);

        // backpressure on the first result
        set_wt(1, 1); lat = 3;
        out_ready = 1'b0;
        push_n(32'd9, 4);
        fd0 = fd_cnt;
        sender_done = 0;
        fork
            begin send_frame(0, 0); sender_done = 1; end
        join_none
        t = 0;
        while (!out_valid && t < 500) begin @(negedge clk); t++; end
        check("t3_out_valid_seen", 72'(out_valid), 72'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("t3_hold_valid", 72'(out_valid), 72'd1);
            check("t3_hold_data",  72'(out_data),  72'd9);
            check("t3_hold_ready", 72'(pix_ready), 72'd0);
            check("t3_hold_win",   win_flat,       WIN_ONES);
        end
        @(posedge clk); #1;
        acc0 = n_acc;
        out_ready = 1'b1;
        t = 0;
        while (n_acc == acc0 && t < 20) begin @(posedge clk); #1; t++; end
        check("t3_next_pixel", 72'(n_acc > acc0), 72'd1);
        t = 0;
        while (!sender_done && t < 2000) begin @(posedge clk); #1; t++; end
        check("t3_sender_done", 72'(sender_done), 72'd1);
        wait_drain("t3_drain");
        check("t3_frame_done", 72'(fd_cnt - fd0), 72'd1);

        // weights all -1 -> -9, or 0 when rectified
        set_wt(-1, -1); lat = 2;
        push_n(NEG9_EXP, 4);
        send_frame(0, 1);
        wait_drain("t4_drain");

        // reset while waiting on the second window's result
        set_wt(1, 1); lat = 4;
        push_n(32'd9, 1);
        fd0 = fd_cnt;
        acc0 = n_starts;
        sender_done = 0;
        abort = 0;
        fork
            begin send_frame(0, 0); sender_done = 1; end
        join_none
        t = 0;
        while (!(n_starts == acc0 + 2 && dbg_state == 3'd3) && t < 1000) begin
            @(negedge clk); t++;
        end
        check("t5_reached_wait", 72'(dbg_state), 72'd3);
        rst_n = 1'b0;
        abort = 1;
        #1;
        check("t5_pix_ready",  72'(pix_ready),  72'd0);
        check("t5_conv_start", 72'(conv_start), 72'd0);
        check("t5_out_valid",  72'(out_valid),  72'd0);
        check("t5_frame_done", 72'(frame_done), 72'd0);
        check("t5_out_data",   72'(out_data),   72'd0);
        check("t5_win_flat",   win_flat,        72'd0);
        check("t5_state_idle", 72'(dbg_state),  72'd0);
        check("t5_q_empty",    72'(exp_q.size()), 72'd0);
        t = 0;
        while (!sender_done && t < 50) begin @(negedge clk); t++; end
        check("t5_sender_abort", 72'(sender_done), 72'd1);
        @(negedge clk);
        rst_n = 1'b1;
        abort = 0;
        @(posedge clk); #1;
        lat = 2;
        push_n(32'd9, 4);
        send_frame(0, 0);
        wait_drain("t5_drain");
        check("t5_frame_done_cnt", 72'(fd_cnt - fd0), 72'd1);

        // two back-to-back ramp frames with stalling input and random engine latency
        set_wt(0, 1); lat = 0;
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back(32'd5); exp_q.push_back(32'd6);
            exp_q.push_back(32'd9); exp_q.push_back(32'd10);
        end
        fd0 = fd_cnt;
        send_frame(1, 1);
        send_frame(1, 1);
        wait_drain("t6_drain");
        check("t6_frame_done", 72'(fd_cnt - fd0), 72'd2);
        check("conv_start_width", 72'(wide_start), 72'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global bound on run length
    initial begin : watchdog
        #400000;
        n_checks++;
        $display("FAIL global_timeout got=running exp=finished @%0t", $time);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_window_feeder.md
# conv_window_feeder

Initiator-side companion to the serial 3x3 convolution engine. Accepts a raster-order pixel stream, buffers two image rows and builds each valid 3x3 window. For each window it pulses `conv_start` and holds the window stable until `conv_done`. It then returns the engine's result on a valid/ready output stream. It sits between the image source and the conv engine; weights are wired to the engine directly and do not pass through this block.

## Interface
- `DATA_WIDTH`, 8: pixel width, signed.
- `ACC_WIDTH`, 32: result width, signed.
- `IMG_W`, 8: image width in pixels, ≥3.
- `IMG_H`, 8: image height in rows, ≥3.
- `clk`  in  1: single clock, all logic on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `pix_valid`  in  1: input pixel valid.
- `pix_ready`  out  1: block can accept a pixel; high only in FILL.
- `pix_data`  in  DATA_WIDTH: signed pixel, raster order.
- `win_flat`  out  9*DATA_WIDTH: window taps a0..a8, a0 in LSBs. a0 = top-left (oldest row, oldest column), a8 = bottom-right (newest pixel), row-major.
- `conv_start`  out  1: one-cycle start pulse to the engine.
- `conv_done`  in  1: engine completion pulse.
- `conv_result`  in  ACC_WIDTH: engine result, valid while `conv_done` is high.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: downstream accepts the result.
- `out_data`  out  ACC_WIDTH: signed result.
- `frame_done`  out  1: one-cycle pulse after the last result of a frame is accepted.

## Operation
- Row counter and column counter track the position of each accepted pixel. Columns wrap at IMG_W-1; rows wrap at IMG_H-1. Both counters return to 0 after the last pixel of a frame.
- Line buffer holds two rows. The 3x3 window shifts by one column on every accepted pixel.
- A window is valid when row≥2 and col≥2 (valid-only convolution).
  - This gives (IMG_W-2)*(IMG_H-2) results per frame, emitted in raster order.
- FSM states:
  - IDLE: reset state; moves to FILL the next cycle.
  - FILL: `pix_ready`=1. On a handshake that completes a valid window, go to ISSUE; otherwise stay in FILL.
  - ISSUE: `conv_start`=1 for this one cycle; go to WAIT.
  - WAIT: hold the window. When `conv_done` is high, capture `conv_result` into `out_data` and go to OUT.
  - OUT: `out_valid`=1 until `out_ready`. On the handshake:
    - If this was the frame's last window, pulse `frame_done` and go to FILL with counters at 0.
    - Otherwise go to FILL.
- `conv_done` outside WAIT is ignored.
- `pix_valid` outside FILL is not accepted and leaves all state unchanged.
- Pixels with row<2 or col<2 are buffered but do not trigger ISSUE.
- Arithmetic: this block performs none. `out_data` is `conv_result` passed through as a full-width copy, or rectified when `CONV_RELU_EN` is defined.

## Timing
- Reset values:
  - `pix_ready`, `conv_start`, `out_valid` and `frame_done` are 0.
  - `out_data` and `win_flat` are 0.
  - Line buffer contents, counters and state (IDLE) are all cleared.
- `pix_ready` rises one cycle after reset release.
- Pixel handshake at edge N completes a valid window → `win_flat` is updated at edge N. `conv_start` is high for the cycle after edge N, through edge N+1.
- `win_flat` is stable from ISSUE until the return to FILL.
- `out_valid` rises at the edge after the one where `conv_done` is sampled. `out_data` does not change while `out_valid`=1.
- `pix_ready` is 0 from ISSUE through the OUT handshake, so a window that is in flight is never disturbed.
- Reset mid-operation (any state): immediate return to reset values. The engine shares `rst_n` and is reset with this block. The next frame starts at row 0, column 0.

## Configuration
- `CONV_RELU_EN` defined: `out_data` = `conv_result` if the sign bit is 0, else 0.
- `CONV_RELU_EN` undefined: `out_data` = `conv_result`, unmodified.

## Structure
- Package `conv_pkg` holds:
  - the state enum (IDLE, FILL, ISSUE, WAIT, OUT);
  - `WIN_TAPS`=9;
  - the tap index constants for a0..a8.
- Sub-module `line_buffer3`:
  - two IMG_W-deep row delays plus the 3x3 shift register;
  - shift-enable input, `win_flat` output.
- The top level contains the counters, FSM and output register.

## Test plan
- IMG_W=IMG_H=4, all pixels 1, engine weights all 1:
  - 4 results, each 9;
  - `frame_done` pulses once, after the 4th handshake.
- IMG_W=IMG_H=4, pixels ramp 0..15, engine weight w4=1 and all others 0:
  - results 5, 6, 9, 10, in that order.
- Backpressure: hold `out_ready`=0 for 10 cycles after the first `out_valid`:
  - `out_valid` stays 1, `out_data` is stable, `pix_ready`=0 and `win_flat` is unchanged;
  - release → the next pixel is accepted.
- All pixels 1, weights all -1:
  - `out_data`=-9 without `CONV_RELU_EN`, 0 with it.
- Assert `rst_n`=0 during WAIT of the 2nd window:
  - all outputs go to 0 immediately;
  - a fresh 4x4 all-ones frame then yields four 9s.
- Two back-to-back 4x4 frames with stalling `pix_valid`:
  - 8 correct results and two `frame_done` pulses;
  - `conv_start` is only ever one cycle wide.
